// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Multiplexed N-digit 7-segment display controller for a common-anode display.
// It scans one digit per slot and applies 16-level PWM dimming inside each slot.
// It also blanks leading zeros and decodes each nibble to a hex glyph.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   en             display enable (0 blanks outputs and parks the scan at digit 0)
//   dim_up_pls     one-cycle pulse, brightness +1 (saturates at 15)
//   dim_dwn_pls    one-cycle pulse, brightness -1 (saturates at 0)
//   dim_val        current brightness level, 0 = dimmest, 15 = full
//   x              packed nibbles, digit i = x[4i+3:4i], digit 0 rightmost
//   x_dp           per-digit decimal point request, 1 = lit
//   seg            segments {g,f,e,d,c,b,a}, active-low
//   dp             decimal point, active-low
//   an             digit anodes, active-low, at most one low at a time
module seg7_scan_ctrl #(
  parameter int N_DIG    = 4,
  parameter int SLOT_CYC = 100_000,
  parameter int BLANK_LZ = 1,
  parameter int DIM_RST  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dim_up_pls,
  input  logic               dim_dwn_pls,
  output logic [3:0]         dim_val,
  input  logic [4*N_DIG-1:0] x,
  input  logic [N_DIG-1:0]   x_dp,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [N_DIG-1:0]   an
);

  localparam int SUB_CYC = SLOT_CYC / 16;
  localparam int SUB_W   = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
  localparam int IDX_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

  // The slot counter is kept as {pwm_idx, sub_cnt}. pwm_idx is the PWM sub
  // interval number, so no divider is needed to find it.
  logic [SUB_W-1:0] sub_cnt;
  logic [3:0]       pwm_idx;
  logic [IDX_W-1:0] idx;
  logic             slot_start;

  logic [3:0]       lat_nib;
  logic             lat_dp;
  logic             lat_blank;
  logic [3:0]       lat_dim;

  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic             cur_blank;
  logic [N_DIG-1:0] blank_vec;
  logic             zero_above;

  logic [3:0]       eff_nib;
  logic             eff_dp;
  logic             eff_blank;
  logic [3:0]       eff_dim;
  logic             lit;
  logic [N_DIG-1:0] an_sel;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign slot_start = (sub_cnt == '0) && (pwm_idx == 4'd0);

  // Scan counters. They are held at zero while disabled, so re-enabling
  // always restarts at digit 0, slot position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      pwm_idx <= 4'd0;
      idx     <= '0;
    end else if (!en) begin
      sub_cnt <= '0;
      pwm_idx <= 4'd0;
      idx     <= '0;
    end else if (sub_cnt == SUB_LAST) begin
      sub_cnt <= '0;
      pwm_idx <= pwm_idx + 4'd1;
      if (pwm_idx == 4'hF) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
    end else begin
      sub_cnt <= sub_cnt + SUB_W'(1);
    end
  end

  // Blanking runs from the most significant digit downward. A digit is
  // blanked only while it and every digit above it are zero with no dp.
  always_comb begin
    blank_vec  = '0;
    zero_above = 1'b1;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      zero_above   = zero_above && (x[4*i +: 4] == 4'h0) && !x_dp[i];
      blank_vec[i] = zero_above && (BLANK_LZ != 0);
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = x[4*i +: 4];
        cur_dp    = x_dp[i];
        cur_blank = blank_vec[i];
      end
    end
  end

  // Slot-start snapshot. In the first cycle of a slot the live values feed
  // the output directly; they are frozen from the second cycle onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_nib   <= 4'h0;
      lat_dp    <= 1'b0;
      lat_blank <= 1'b0;
      lat_dim   <= 4'(DIM_RST);
    end else if (en && slot_start) begin
      lat_nib   <= cur_nib;
      lat_dp    <= cur_dp;
      lat_blank <= cur_blank;
      lat_dim   <= dim_val;
    end
  end

  always_comb begin
    eff_nib   = slot_start ? cur_nib   : lat_nib;
    eff_dp    = slot_start ? cur_dp    : lat_dp;
    eff_blank = slot_start ? cur_blank : lat_blank;
    eff_dim   = slot_start ? dim_val   : lat_dim;
    lit       = en && !eff_blank && (pwm_idx <= eff_dim);
    an_sel    = '1;
    for (int i = 0; i < N_DIG; i++) begin
      if (idx == IDX_W'(i)) begin
        an_sel[i] = 1'b0;
      end
    end
  end

  // Registered outputs. Every output goes inactive in the same edge whenever
  // the digit is unlit, blanked or disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (lit) begin
      an  <= an_sel;
      seg <= hex_to_seg(eff_nib);
      dp  <= ~eff_dp;
    end else begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end
  end

  // Brightness register. Simultaneous up and down pulses cancel each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_val <= 4'(DIM_RST);
    end else if (dim_up_pls && !dim_dwn_pls && (dim_val != 4'hF)) begin
      dim_val <= dim_val + 4'd1;
    end else if (dim_dwn_pls && !dim_up_pls && (dim_val != 4'h0)) begin
      dim_val <= dim_val - 4'd1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl.
// Two instances share the same stimulus: one with leading-zero blanking
// enabled and one with it disabled. A slot-level behavioural model predicts
// an/seg/dp/dim_val for both instances every cycle. Literal checks pin down
// the scan order, the PWM duty, saturation, blanking and the enable/reset
// behaviour.
module tb_seg7_scan_ctrl;

  localparam int N_DIG    = 4;
  localparam int SLOT_CYC = 32;
  localparam int SUB_CYC  = SLOT_CYC / 16;
  localparam int DIM_RST  = 15;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        dim_up_pls = 1'b0;
  logic        dim_dwn_pls = 1'b0;
  logic [15:0] x = 16'h0;
  logic [3:0]  x_dp = 4'h0;
  logic [3:0]  dim_val, dim_val0;
  logic [6:0]  seg, seg0;
  logic        dp, dp0;
  logic [3:0]  an, an0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.N_DIG(N_DIG), .SLOT_CYC(SLOT_CYC), .BLANK_LZ(1), .DIM_RST(DIM_RST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dim_up_pls(dim_up_pls), .dim_dwn_pls(dim_dwn_pls),
    .dim_val(dim_val), .x(x), .x_dp(x_dp), .seg(seg), .dp(dp), .an(an)
  );

  seg7_scan_ctrl #(.N_DIG(N_DIG), .SLOT_CYC(SLOT_CYC), .BLANK_LZ(0), .DIM_RST(DIM_RST)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .dim_up_pls(dim_up_pls), .dim_dwn_pls(dim_dwn_pls),
    .dim_val(dim_val0), .x(x), .x_dp(x_dp), .seg(seg0), .dp(dp0), .an(an0)
  );

  // Behavioural model state: position within the slot (0..SLOT_CYC-1), the
  // digit being scanned, brightness, and the values captured at slot start.
  int         m_t = 0;
  int         m_d = 0;
  logic [3:0] m_dim = 4'(DIM_RST);
  logic [3:0] m_nib = 4'h0;
  logic       m_dpl = 1'b0;
  logic       m_blank = 1'b0;
  logic [3:0] m_ldim = 4'(DIM_RST);
  logic [3:0] e_an = 4'hF, e_an0 = 4'hF;
  logic [6:0] e_seg = 7'h7F, e_seg0 = 7'h7F;
  logic       e_dp = 1'b1, e_dp0 = 1'b1;
  bit         m_valid = 1'b0;
  bit         m_lit;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t = 0; m_d = 0; m_dim = 4'(DIM_RST); m_ldim = 4'(DIM_RST);
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        e_an0 = 4'hF; e_seg0 = 7'h7F; e_dp0 = 1'b1;
        m_valid = 1'b1;
      end else begin
        if (!en) begin
          e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
          e_an0 = 4'hF; e_seg0 = 7'h7F; e_dp0 = 1'b1;
          m_t = 0; m_d = 0;
        end else begin
          if (m_t == 0) begin
            m_nib   = x[4*m_d +: 4];
            m_dpl   = x_dp[m_d];
            m_blank = (m_d != 0) && ((x >> (4*m_d)) == 16'h0) && ((x_dp >> m_d) == 4'h0);
            m_ldim  = m_dim;
          end
          m_lit  = (m_t / SUB_CYC) <= int'(m_ldim);
          e_an0  = m_lit ? ~(4'b0001 << m_d) : 4'hF;
          e_seg0 = m_lit ? HEX_TAB[m_nib] : 7'h7F;
          e_dp0  = m_lit ? ~m_dpl : 1'b1;
          e_an   = (m_lit && !m_blank) ? e_an0 : 4'hF;
          e_seg  = (m_lit && !m_blank) ? e_seg0 : 7'h7F;
          e_dp   = (m_lit && !m_blank) ? e_dp0 : 1'b1;
          m_t++;
          if (m_t == SLOT_CYC) begin
            m_t = 0;
            m_d = (m_d + 1) % N_DIG;
          end
        end
        if (dim_up_pls && !dim_dwn_pls && m_dim < 15) m_dim = m_dim + 4'd1;
        else if (dim_dwn_pls && !dim_up_pls && m_dim > 0) m_dim = m_dim - 4'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_valid) begin
        checkOutput("model an",       32'(an),       32'(e_an));
        checkOutput("model seg",      32'(seg),      32'(e_seg));
        checkOutput("model dp",       32'(dp),       32'(e_dp));
        checkOutput("model dim_val",  32'(dim_val),  32'(m_dim));
        checkOutput("model an0",      32'(an0),      32'(e_an0));
        checkOutput("model seg0",     32'(seg0),     32'(e_seg0));
        checkOutput("model dp0",      32'(dp0),      32'(e_dp0));
        checkOutput("model dim_val0", 32'(dim_val0), 32'(m_dim));
      end
    end
  end

  // One-cycle dimming pulse, followed by one idle cycle.
  task automatic applyStimulus(input logic up, input logic dn);
    dim_up_pls  = up;
    dim_dwn_pls = dn;
    @(negedge clk);
    dim_up_pls  = 1'b0;
    dim_dwn_pls = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitAn(input logic [3:0] want, input string name);
    int n = 0;
    while (an !== want && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(an), 32'(want));
  endtask

  int lit_cnt [4];
  int lit_cnt0 [4];

  // Over one full scan period (128 cycles), count how many cycles each anode is low.
  task automatic countLit();
    for (int i = 0; i < 4; i++) begin
      lit_cnt[i]  = 0;
      lit_cnt0[i] = 0;
    end
    repeat (N_DIG * SLOT_CYC) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!an[i])  lit_cnt[i]++;
        if (!an0[i]) lit_cnt0[i]++;
      end
    end
  endtask

  logic [3:0] an_seq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_seq [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] abcd    [4] = '{7'h21, 7'h46, 7'h03, 7'h08};

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    x     = 16'h1234;
    x_dp  = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset an",  32'(an),      32'hF);
    checkOutput("reset seg", 32'(seg),     32'h7F);
    checkOutput("reset dp",  32'(dp),      32'h1);
    checkOutput("reset dim", 32'(dim_val), 32'(DIM_RST));

    // Scan order and glyphs after reset release.
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checkOutput("scan an",  32'(an),  32'(an_seq[k]));
      checkOutput("scan seg", 32'(seg), 32'(seg_seq[k]));
      repeat (SLOT_CYC) @(negedge clk);
    end

    // PWM duty at dim 3 and dim 0.
    repeat (12) applyStimulus(1'b0, 1'b1);
    checkOutput("dim after 12 down", 32'(dim_val), 32'd3);
    repeat (N_DIG * SLOT_CYC) @(negedge clk);
    countLit();
    for (int i = 0; i < 4; i++) checkOutput("pwm dim3 lit cycles", 32'(lit_cnt[i]), 32'd8);
    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (N_DIG * SLOT_CYC) @(negedge clk);
    countLit();
    for (int i = 0; i < 4; i++) checkOutput("pwm dim0 lit cycles", 32'(lit_cnt[i]), 32'd2);

    // Saturation in both directions and cancelling pulses.
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (k == 15 || k == 20) checkOutput("dim up sat", 32'(dim_val), 32'd15);
    end
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b1);
      if (k == 15 || k == 20) checkOutput("dim down sat", 32'(dim_val), 32'd0);
    end
    repeat (7) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("dim both pulses", 32'(dim_val), 32'd7);
    repeat (8) applyStimulus(1'b1, 1'b0);

    // Leading-zero blanking.
    x = 16'h0050;
    x_dp = 4'b0000;
    repeat (N_DIG * SLOT_CYC) @(negedge clk);
    countLit();
    checkOutput("blank d0", 32'(lit_cnt[0]), 32'd32);
    checkOutput("blank d1", 32'(lit_cnt[1]), 32'd32);
    checkOutput("blank d2", 32'(lit_cnt[2]), 32'd0);
    checkOutput("blank d3", 32'(lit_cnt[3]), 32'd0);
    for (int i = 0; i < 4; i++) checkOutput("noblank lit", 32'(lit_cnt0[i]), 32'd32);
    x_dp = 4'b0100;
    repeat (N_DIG * SLOT_CYC) @(negedge clk);
    countLit();
    checkOutput("dp blank d2", 32'(lit_cnt[2]), 32'd32);
    checkOutput("dp blank d3", 32'(lit_cnt[3]), 32'd0);
    waitAn(4'b1011, "wait digit2 dp");
    checkOutput("digit2 seg", 32'(seg), 32'h40);
    checkOutput("digit2 dp",  32'(dp),  32'h0);

    // Hex glyphs and mid-slot latching.
    x = 16'hABCD;
    x_dp = 4'b0000;
    repeat (N_DIG * SLOT_CYC) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      waitAn(an_seq[k], "wait hex digit");
      checkOutput("hex seg", 32'(seg), 32'(abcd[k]));
    end
    waitAn(4'b1101, "wait latch d1");
    waitAn(4'b1110, "wait latch d0");
    repeat (10) @(negedge clk);
    x = 16'h1235;
    @(negedge clk);
    checkOutput("latch hold seg", 32'(seg), 32'h21);
    repeat (5) @(negedge clk);
    checkOutput("latch hold seg late", 32'(seg), 32'h21);
    waitAn(4'b1101, "wait next d1");
    waitAn(4'b1110, "wait next d0");
    checkOutput("latch new seg", 32'(seg), 32'h12);

    // Drop en mid-slot of digit 2, then restart from digit 0.
    waitAn(4'b1011, "wait en d2");
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("en off an", 32'(an), 32'hF);
    repeat (4) @(negedge clk);
    checkOutput("en off hold an", 32'(an), 32'hF);
    en = 1'b1;
    @(negedge clk);
    checkOutput("en restart an", 32'(an), 32'hE);

    // Randomized operation, checked by the model every cycle.
    repeat (3000) begin
      @(negedge clk);
      en          = ($urandom_range(0, 299) != 0);
      dim_up_pls  = ($urandom_range(0, 19) == 0);
      dim_dwn_pls = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) x = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) x_dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
    en = 1'b1;
    dim_up_pls = 1'b0;
    dim_dwn_pls = 1'b0;
    x = 16'h8888;
    repeat (SLOT_CYC + 5) @(negedge clk);
    checkOutput("pre-reset lit", 32'(an0 != 4'hF), 32'd1);

    // Asynchronous reset in the middle of a slot.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async an",  32'(an),       32'hF);
    checkOutput("async seg", 32'(seg),      32'h7F);
    checkOutput("async dp",  32'(dp),       32'h1);
    checkOutput("async dim", 32'(dim_val),  32'(DIM_RST));
    checkOutput("async an0", 32'(an0),      32'hF);
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
